// File: rtl/axil_window_bridge.sv
// AXI4-Lite single-window bridge: forwards accesses inside [BASE, BASE+SIZE) with the
// address rebased to OFFSET and optional byte swap; answers everything else locally with DECERR.
module axil_window_bridge #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DEST_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE          = '0,
  parameter logic [ADDR_WIDTH-1:0] SIZE          = ADDR_WIDTH'(32'h1000_0000),
  parameter logic [ADDR_WIDTH-1:0] OFFSET        = '0,
  parameter bit                    CHANGE_ENDIAN = 1'b0,
  localparam int                   STRB          = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [2:0]            s_arprot,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [2:0]            s_awprot,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB-1:0]       s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [DEST_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [DEST_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB-1:0]       m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [15:0]           err_count,
  output logic [3:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
  // a valid, once raised, holds its payload stable until that edge.

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B, W_RESP} w_state_t;

  r_state_t r_state, r_state_d;
  w_state_t w_state, w_state_d;

  assign dbg_state = {r_state, w_state};

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] rel;
    rel = a - BASE;
    return (a >= BASE) && (rel < SIZE);
  endfunction

  function automatic logic [DEST_WIDTH-1:0] translate(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] t;
    t = a - BASE + OFFSET;
    return DEST_WIDTH'(t);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] swap_data(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] o;
    o = d;
    if (CHANGE_ENDIAN)
      for (int i = 0; i < STRB; i++) o[8*i +: 8] = d[8*(STRB-1-i) +: 8];
    return o;
  endfunction

  function automatic logic [STRB-1:0] swap_strb(input logic [STRB-1:0] s);
    logic [STRB-1:0] o;
    o = s;
    if (CHANGE_ENDIAN)
      for (int i = 0; i < STRB; i++) o[i] = s[STRB-1-i];
    return o;
  endfunction

  // ---------------- read channel ----------------
  logic                  s_arready_d, m_arvalid_d, m_rready_d, s_rvalid_d, rd_err;
  logic [DEST_WIDTH-1:0] m_araddr_d;
  logic [2:0]            m_arprot_d;
  logic [DATA_WIDTH-1:0] s_rdata_d;
  logic [1:0]            s_rresp_d;

  always_comb begin
    r_state_d   = r_state;
    s_arready_d = s_arready;
    m_arvalid_d = m_arvalid;
    m_araddr_d  = m_araddr;
    m_arprot_d  = m_arprot;
    m_rready_d  = m_rready;
    s_rvalid_d  = s_rvalid;
    s_rdata_d   = s_rdata;
    s_rresp_d   = s_rresp;
    rd_err      = 1'b0;
    case (r_state)
      R_IDLE: if (s_arvalid && s_arready) begin
        s_arready_d = 1'b0;
        if (in_window(s_araddr)) begin
          r_state_d   = R_ADDR;
          m_arvalid_d = 1'b1;
          m_araddr_d  = translate(s_araddr);
          m_arprot_d  = s_arprot;
        end else begin
          r_state_d  = R_RESP;
          s_rvalid_d = 1'b1;
          s_rdata_d  = '0;
          s_rresp_d  = 2'b11;
          rd_err     = 1'b1;
        end
      end
      R_ADDR: if (m_arready) begin
        r_state_d   = R_DATA;
        m_arvalid_d = 1'b0;
        m_rready_d  = 1'b1;
      end
      R_DATA: if (m_rvalid) begin
        r_state_d  = R_RESP;
        m_rready_d = 1'b0;
        s_rvalid_d = 1'b1;
        s_rdata_d  = swap_data(m_rdata);
        s_rresp_d  = m_rresp;
      end
      R_RESP: if (s_rready) begin
        r_state_d   = R_IDLE;
        s_rvalid_d  = 1'b0;
        s_arready_d = 1'b1;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b1;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arprot  <= '0;
      m_rready  <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= '0;
    end else begin
      r_state   <= r_state_d;
      s_arready <= s_arready_d;
      m_arvalid <= m_arvalid_d;
      m_araddr  <= m_araddr_d;
      m_arprot  <= m_arprot_d;
      m_rready  <= m_rready_d;
      s_rvalid  <= s_rvalid_d;
      s_rdata   <= s_rdata_d;
      s_rresp   <= s_rresp_d;
    end
  end

  // ---------------- write channel ----------------
  logic                  aw_held, aw_held_d, w_held, w_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, aw_addr_eff;
  logic [2:0]            aw_prot_q, aw_prot_d, aw_prot_eff;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d, w_data_eff;
  logic [STRB-1:0]       w_strb_q, w_strb_d, w_strb_eff;
  logic                  aw_hs, w_hs;
  logic                  s_awready_d, s_wready_d, m_awvalid_d, m_wvalid_d, m_bready_d, s_bvalid_d, wr_err;
  logic [DEST_WIDTH-1:0] m_awaddr_d;
  logic [2:0]            m_awprot_d;
  logic [DATA_WIDTH-1:0] m_wdata_d;
  logic [STRB-1:0]       m_wstrb_d;
  logic [1:0]            s_bresp_d;

  assign aw_hs       = s_awvalid && s_awready;
  assign w_hs        = s_wvalid && s_wready;
  // The half arriving this cycle is used directly so forwarding starts without an extra bubble.
  assign aw_addr_eff = aw_held ? aw_addr_q : s_awaddr;
  assign aw_prot_eff = aw_held ? aw_prot_q : s_awprot;
  assign w_data_eff  = w_held ? w_data_q : s_wdata;
  assign w_strb_eff  = w_held ? w_strb_q : s_wstrb;

  always_comb begin
    w_state_d   = w_state;
    aw_held_d   = aw_held;
    w_held_d    = w_held;
    aw_addr_d   = aw_addr_q;
    aw_prot_d   = aw_prot_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    s_awready_d = s_awready;
    s_wready_d  = s_wready;
    m_awvalid_d = m_awvalid;
    m_awaddr_d  = m_awaddr;
    m_awprot_d  = m_awprot;
    m_wvalid_d  = m_wvalid;
    m_wdata_d   = m_wdata;
    m_wstrb_d   = m_wstrb;
    m_bready_d  = m_bready;
    s_bvalid_d  = s_bvalid;
    s_bresp_d   = s_bresp;
    wr_err      = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d   = 1'b1;
          s_awready_d = 1'b0;
          aw_addr_d   = s_awaddr;
          aw_prot_d   = s_awprot;
        end
        if (w_hs) begin
          w_held_d   = 1'b1;
          s_wready_d = 1'b0;
          w_data_d   = s_wdata;
          w_strb_d   = s_wstrb;
        end
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          if (in_window(aw_addr_eff)) begin
            w_state_d   = W_REQ;
            m_awvalid_d = 1'b1;
            m_awaddr_d  = translate(aw_addr_eff);
            m_awprot_d  = aw_prot_eff;
            m_wvalid_d  = 1'b1;
            m_wdata_d   = swap_data(w_data_eff);
            m_wstrb_d   = swap_strb(w_strb_eff);
          end else begin
            w_state_d  = W_RESP;
            s_bvalid_d = 1'b1;
            s_bresp_d  = 2'b11;
            wr_err     = 1'b1;
          end
        end
      end
      W_REQ: begin
        if (m_awready) m_awvalid_d = 1'b0;
        if (m_wready) m_wvalid_d = 1'b0;
        if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
          w_state_d  = W_B;
          m_bready_d = 1'b1;
        end
      end
      W_B: if (m_bvalid) begin
        w_state_d  = W_RESP;
        m_bready_d = 1'b0;
        s_bvalid_d = 1'b1;
        s_bresp_d  = m_bresp;
      end
      W_RESP: if (s_bready) begin
        w_state_d   = W_IDLE;
        s_bvalid_d  = 1'b0;
        s_awready_d = 1'b1;
        s_wready_d  = 1'b1;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      s_awready <= 1'b1;
      s_wready  <= 1'b1;
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_awprot  <= '0;
      m_wvalid  <= 1'b0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_bready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= '0;
    end else begin
      w_state   <= w_state_d;
      aw_held   <= aw_held_d;
      w_held    <= w_held_d;
      aw_addr_q <= aw_addr_d;
      aw_prot_q <= aw_prot_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      s_awready <= s_awready_d;
      s_wready  <= s_wready_d;
      m_awvalid <= m_awvalid_d;
      m_awaddr  <= m_awaddr_d;
      m_awprot  <= m_awprot_d;
      m_wvalid  <= m_wvalid_d;
      m_wdata   <= m_wdata_d;
      m_wstrb   <= m_wstrb_d;
      m_bready  <= m_bready_d;
      s_bvalid  <= s_bvalid_d;
      s_bresp   <= s_bresp_d;
    end
  end

  // ---------------- DECERR counter (saturating) ----------------
  logic [16:0] err_sum;
  assign err_sum = {1'b0, err_count} + 17'(rd_err) + 17'(wr_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count <= '0;
    else     err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

endmodule

// File: doc/axil_window_bridge.md
Name: axil_window_bridge

Overview:
- Parametrised AXI4-Lite single-window address bridge; successor to the fixed 32-bit address adaptor.
- Sits between a bus master (core or interconnect port) and a peripheral.
- Translates addresses in [BASE, BASE+SIZE) to OFFSET-relative addresses and can byte-swap data and strobes.
- Answers out-of-window accesses locally with DECERR, never forwarding them, and counts errors.

Parameters:
- ADDR_WIDTH, 32: slave-side address width.
- DEST_WIDTH, 32: master-side address width; translated address truncated to this.
- DATA_WIDTH, 32: data width, 32 or 64; STRB = DATA_WIDTH/8.
- BASE, 0: window base, slave-side byte address.
- SIZE, 32'h1000_0000: window size in bytes, nonzero.
- OFFSET, 0: added after BASE subtraction.
- CHANGE_ENDIAN, 0: 1 reverses byte order of rdata, wdata and wstrb.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_araddr in ADDR_WIDTH; s_arprot in 3; s_arvalid in 1; s_arready out 1
- s_rdata out DATA_WIDTH; s_rresp out 2; s_rvalid out 1; s_rready in 1
- s_awaddr in ADDR_WIDTH; s_awprot in 3; s_awvalid in 1; s_awready out 1
- s_wdata in DATA_WIDTH; s_wstrb in STRB; s_wvalid in 1; s_wready out 1
- s_bresp out 2; s_bvalid out 1; s_bready in 1
- m_araddr out DEST_WIDTH; m_arprot out 3; m_arvalid out 1; m_arready in 1
- m_rdata in DATA_WIDTH; m_rresp in 2; m_rvalid in 1; m_rready out 1
- m_awaddr out DEST_WIDTH; m_awprot out 3; m_awvalid out 1; m_awready in 1
- m_wdata out DATA_WIDTH; m_wstrb out STRB; m_wvalid out 1; m_wready in 1
- m_bresp in 2; m_bvalid in 1; m_bready out 1
- err_count out 16: saturating count of DECERR responses issued

Behaviour:
- Reset (async assert, sync deassert use): s_arready=s_awready=s_wready=1; every other output 0, including data, addr, resp and err_count.
- Reset mid-transaction aborts it with no response; after release both FSMs are idle.
- All outputs are registered.
- In-window test: (a >= BASE) && (a - BASE < SIZE), evaluated at full ADDR_WIDTH.
- Translation: a - BASE + OFFSET, truncated to DEST_WIDTH.
- Swap (CHANGE_ENDIAN=1): byte i ↔ byte STRB-1-i for rdata and wdata; wstrb bit i ↔ bit STRB-1-i.
- Read FSM (one outstanding):
  - R_IDLE: s_arready=1. AR handshake in cycle N goes to R_ADDR if in window: m_arvalid=1 at N+1 with translated addr and prot. If out of window, goes to R_RESP: s_rvalid=1 at N+1, rdata=0, rresp=2'b11, err_count+1.
  - R_ADDR: on m_arvalid&&m_arready → R_DATA, m_arvalid=0, m_rready=1.
  - R_DATA: on m_rvalid → R_RESP, m_rready=0, s_rvalid=1, s_rdata=(swapped) m_rdata, s_rresp=m_rresp.
  - R_RESP: hold data stable; on s_rready → R_IDLE, s_rvalid=0, s_arready=1.
- Write FSM (one outstanding):
  - W_IDLE: AW and W accepted independently in any order or in the same cycle. Each ready drops on its own handshake; payloads are captured.
  - When both are held: in window → W_REQ next cycle, m_awvalid=m_wvalid=1 in the same cycle. Out of window → W_RESP, bresp=2'b11, err_count+1.
  - W_REQ: each valid drops independently on its handshake. When both have completed (possibly the same cycle) → W_B, m_bready=1.
  - W_B: on m_bvalid → W_RESP, m_bready=0, s_bvalid=1, s_bresp=m_bresp.
  - W_RESP: on s_bready → W_IDLE, s_bvalid=0, s_awready=s_wready=1.
- Read and write FSMs are fully independent and may run concurrently.
- A read DECERR and a write DECERR in the same cycle add 2 to err_count.
- err_count holds at 16'hFFFF.
- Master responses are passed through unmodified, including SLVERR.
- Address arithmetic wraps modulo 2^ADDR_WIDTH before truncation.

Test Plan (BASE=32'h8000_0000, SIZE=32'h1000, OFFSET=32'h2000, DEST_WIDTH=16, CHANGE_ENDIAN=1, DATA_WIDTH=32):
- Read 32'h8000_0010 → m_araddr=16'h2010 one cycle after AR handshake. m_rdata=32'h1122_3344, m_rresp=0 → s_rdata=32'h4433_2211, s_rresp=0.
- Read 32'h8000_1000 (first byte past window) → m_arvalid never rises; s_rvalid next cycle with rdata=0, rresp=2'b11; err_count=1.
- AW 32'h8000_0FFC, then W 3 cycles later with data 32'hAABB_CCDD, strb 4'b0011 → m_awaddr=16'h2FFC, m_wdata=32'hDDCC_BBAA, m_wstrb=4'b1100; both valids rise in the same cycle.
- m_awready same cycle, m_wready 2 cycles later → m_bready rises only after the W handshake. m_bresp=2'b10 → s_bresp=2'b10.
- Concurrent out-of-window read and write in the same cycle → both DECERR; err_count increments by 2. With err_count preloaded to 16'hFFFE via repeated errors, it saturates at 16'hFFFF.
- Assert rst while m_arvalid=1 → all outputs are at reset values within the same cycle. After release a new read completes normally.
